// File: rtl/irq_pc_redirect_pkg.sv
// irq_pc_redirect_pkg
// Shared definitions for the interrupt PC-redirect sequencer: the next-PC mux
// select encodings, the sequencer state type, and a helper that maps a state
// to the select it drives.
package irq_pc_redirect_pkg;

  // Next-PC mux select values. Encoding 2'b01 is reserved and never driven.
  localparam logic [1:0] PCSEL_SEQ = 2'b00;
  localparam logic [1:0] PCSEL_VEC = 2'b10;
  localparam logic [1:0] PCSEL_EPC = 2'b11;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    TAKE    = 2'd1,
    HANDLER = 2'd2,
    RETURN  = 2'd3
  } state_t;

  // The mux select is a pure function of the sequencer state, so the PC
  // redirect is glitch-free and always lines up with the state register.
  function automatic logic [1:0] pc_sel_for(state_t s);
    logic [1:0] sel;
    sel = PCSEL_SEQ;
    case (s)
      TAKE:    sel = PCSEL_VEC;
      RETURN:  sel = PCSEL_EPC;
      default: sel = PCSEL_SEQ;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/irq_pc_redirect_prio_enc.sv
// irq_prio_enc
// Combinational lowest-index-wins priority encoder for the interrupt lines.
// Ports:
//   req   in  NIRQ  eligible request vector
//   valid out 1     at least one request present
//   idx   out 3     index of the lowest set bit (0 when none)
module irq_prio_enc #(
  parameter int NIRQ = 4
) (
  input  logic [NIRQ-1:0] req,
  output logic            valid,
  output logic [2:0]      idx
);

  // Scan from the top down so the last assignment, and therefore the winner,
  // is the lowest-numbered set line.
  always_comb begin
    valid = |req;
    idx   = 3'd0;
    for (int i = NIRQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx = 3'(i);
      end
    end
  end

endmodule

// File: rtl/irq_pc_redirect.sv
// irq_pc_redirect
// Interrupt sequencer that drives the CPU's next-PC 4:1 mux select and
// supplies the handler vector and saved EPC as two of the mux data inputs.
// External interrupt edges are latched into pending, filtered by the mask and
// global enable, and the lowest-index eligible line is taken.
// Ports:
//   clk        in  1        rising-edge clock
//   rst_n      in  1        asynchronous active-low reset
//   irq        in  NIRQ     level request lines, synchronous to clk
//   stall      in  1        pipeline hold; freezes any redirect in progress
//   pc_next    in  WIDTH    fetch address the datapath would use next
//   eret       in  1        decoded ERET
//   mask_we    in  1        mask/enable register write strobe
//   mask_wdata in  NIRQ+1   {global IE, per-line enables}
//   pc_sel     out 2        next-PC mux select (00 seq, 10 vector, 11 EPC)
//   vector     out WIDTH    handler entry address (constant)
//   epc        out WIDTH    saved return address
//   cause      out 3        index of the last taken interrupt
//   in_handler out 1        high from the take until the ERET redirect
//   pending    out NIRQ     latched, not-yet-serviced requests
module irq_pc_redirect
  import irq_pc_redirect_pkg::*;
#(
  parameter int               WIDTH        = 32,
  parameter int               NIRQ         = 4,
  parameter logic [WIDTH-1:0] HANDLER_ADDR = 32'h0000_0800
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NIRQ-1:0]  irq,
  input  logic             stall,
  input  logic [WIDTH-1:0] pc_next,
  input  logic             eret,
  input  logic             mask_we,
  input  logic [NIRQ:0]    mask_wdata,
  output logic [1:0]       pc_sel,
  output logic [WIDTH-1:0] vector,
  output logic [WIDTH-1:0] epc,
  output logic [2:0]       cause,
  output logic             in_handler,
  output logic [NIRQ-1:0]  pending
);

  state_t          state;
  state_t          state_nxt;
  logic [NIRQ-1:0] irq_q;
  logic [NIRQ-1:0] rise;
  logic [NIRQ-1:0] mask_en;
  logic            ie;
  logic [NIRQ-1:0] eligible;
  logic [NIRQ-1:0] clr_mask;
  logic            win_valid;
  logic [2:0]      win_idx;
  logic            take;
  logic            ret_start;

  assign rise     = irq & ~irq_q;
  assign eligible = ie ? (pending & mask_en) : '0;

  irq_prio_enc #(
    .NIRQ (NIRQ)
  ) u_prio_enc (
    .req   (eligible),
    .valid (win_valid),
    .idx   (win_idx)
  );

  // Next-state logic. A take only starts from IDLE on an unstalled cycle with
  // no ERET present; every other state simply holds while stall is high.
  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    ret_start = 1'b0;
    case (state)
      IDLE: begin
        if (!stall && win_valid && !eret) begin
          take      = 1'b1;
          state_nxt = TAKE;
        end
      end
      TAKE: begin
        if (!stall) begin
          state_nxt = HANDLER;
        end
      end
      HANDLER: begin
        if (eret && !stall) begin
          ret_start = 1'b1;
          state_nxt = RETURN;
        end
      end
      RETURN: begin
        if (!stall) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // One-hot clear of the winning pending bit, only on the take cycle.
  always_comb begin
    clr_mask = '0;
    for (int i = 0; i < NIRQ; i++) begin
      clr_mask[i] = take && (win_idx == 3'(i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Edge capture. The rise term is OR-ed in after the clear so that a new
  // edge arriving on the same cycle its line is serviced is never dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_q   <= '0;
      pending <= '0;
    end else begin
      irq_q   <= irq;
      pending <= (pending & ~clr_mask) | rise;
    end
  end

  // Mask/enable register. Software writes land first; a take then forces IE
  // off (overriding a written IE in the same cycle) and the ERET redirect
  // turns it back on. Nothing new is taken until the sequencer is back in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_en <= '0;
      ie      <= 1'b0;
    end else begin
      if (mask_we) begin
        mask_en <= mask_wdata[NIRQ-1:0];
        ie      <= mask_wdata[NIRQ];
      end
      if (take) begin
        ie <= 1'b0;
      end else if (ret_start) begin
        ie <= 1'b1;
      end
    end
  end

  // Return address and cause are captured only at a take and otherwise hold,
  // so ERET reads back exactly the address that was interrupted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      epc   <= '0;
      cause <= 3'd0;
    end else if (take) begin
      epc   <= pc_next;
      cause <= win_idx;
    end
  end

  assign pc_sel     = pc_sel_for(state);
  assign in_handler = (state != IDLE);
  assign vector     = HANDLER_ADDR;

endmodule
